game_control: RTL

GAME_CONTROL -- requirements
Module: game_control

---
 rtl/game_pkg.sv | 14 +
 rtl/game_control_if.sv | 12 +
 rtl/game_control_score_counter.sv | 21 ++
 rtl/game_control.sv | 126 ++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and state encoding for the game controller and its helpers.
package game_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_ERASE, ST_MOVE, ST_DRAW, ST_DETECT, ST_HIT, ST_OVER
  } state_e;

  localparam int LIVES_INIT        = 3;
  localparam int FRAMES_PER_POINT  = 60;
  localparam int HIT_FREEZE_FRAMES = 30;
  localparam int SCORE_W           = 10;
  localparam int SCORE_MAX         = 999;
  localparam int SCREEN_W          = 160;
  localparam int SCREEN_H          = 120;
endpackage

// File: rtl/game_control_if.sv
// Request/done handshake between the game controller and the erase/draw/collision engines.
interface game_control_if;
  logic start_erase, done_erase;
  logic start_draw, done_draw;
  logic detectCollide, doneDetect, collide;
  logic move_en;

  modport master (output start_erase, start_draw, detectCollide, move_en,
                  input  done_erase, done_draw, doneDetect, collide);
  modport slave  (input  start_erase, start_draw, detectCollide, move_en,
                  output done_erase, done_draw, doneDetect, collide);
endinterface

// File: rtl/game_control_score_counter.sv
// Saturating score counter: synchronous clear, single-step increment, holds at CAP.
module score_counter #(
  parameter int W   = 10,
  parameter int CAP = 999
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_score
);
  logic [W-1:0] r_score;

  always_ff @(posedge clk) begin
    if (!reset)                                r_score <= '0;
    else if (i_clear)                          r_score <= '0;
    else if (i_inc && (r_score != W'(CAP)))    r_score <= r_score + 1'b1;
  end

  assign o_score = r_score;
endmodule

// File: rtl/game_control.sv
// Frame sequencer: erase -> move -> draw -> detect per frame_tick, tracking lives, score and hit freeze.
module game_control #(
  parameter int LIVES_INIT        = game_pkg::LIVES_INIT,
  parameter int FRAMES_PER_POINT  = game_pkg::FRAMES_PER_POINT,
  parameter int HIT_FREEZE_FRAMES = game_pkg::HIT_FREEZE_FRAMES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  space_pressed,
  input  logic                  frame_tick,
  game_control_if.master        eng,
  output logic [1:0]            lives,
  output logic [9:0]            score,
  output logic                  playing,
  output logic                  game_over,
  output logic                  frame_overrun
);
  import game_pkg::*;

  localparam int FCW = $clog2(FRAMES_PER_POINT + 1);
  localparam int FZW = $clog2(HIT_FREEZE_FRAMES + 1);

  state_e         r_state, w_next;
  logic [1:0]     r_lives;
  logic [FCW-1:0] r_frame;
  logic [FZW-1:0] r_freeze;
  logic           r_overrun;

  logic w_start, w_clean, w_hit, w_fatal, w_freeze_inc, w_overrun, w_frame_wrap;

  assign w_frame_wrap = (r_frame == FCW'(FRAMES_PER_POINT - 1));

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_start      = 1'b0;
    w_clean      = 1'b0;
    w_hit        = 1'b0;
    w_fatal      = 1'b0;
    w_freeze_inc = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      // A tick arriving with the start press is deliberately not consumed.
      ST_IDLE, ST_OVER: if (space_pressed) begin
        w_next  = ST_WAIT;
        w_start = 1'b1;
      end
      ST_WAIT:  if (frame_tick) w_next = ST_ERASE;
      ST_ERASE: begin
        w_overrun = frame_tick;
        if (eng.done_erase) w_next = ST_MOVE;
      end
      ST_MOVE: begin
        w_overrun = frame_tick;
        w_next    = ST_DRAW;
      end
      ST_DRAW: begin
        w_overrun = frame_tick;
        if (eng.done_draw) w_next = ST_DETECT;
      end
      ST_DETECT: begin
        w_overrun = frame_tick;
        if (eng.doneDetect) begin
          if (!eng.collide) begin
            w_clean = 1'b1;
            w_next  = ST_WAIT;
          end else if (r_lives > 2'd1) begin
            w_hit  = 1'b1;
            w_next = ST_HIT;
          end else begin
            w_fatal = 1'b1;
            w_next  = ST_OVER;
          end
        end
      end
      ST_HIT: if (frame_tick) begin
        if (r_freeze == FZW'(HIT_FREEZE_FRAMES - 1)) w_next = ST_WAIT;
        else                                          w_freeze_inc = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lives   <= '0;
      r_frame   <= '0;
      r_freeze  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overrun;
      if (w_start) begin
        r_lives <= 2'(LIVES_INIT);
        r_frame <= '0;
      end
      if (w_clean)      r_frame  <= w_frame_wrap ? '0 : r_frame + 1'b1;
      if (w_hit) begin
        r_lives  <= r_lives - 2'd1;
        r_freeze <= '0;
      end
      if (w_fatal)      r_lives  <= '0;
      if (w_freeze_inc) r_freeze <= r_freeze + 1'b1;
    end
  end

  score_counter #(.W(SCORE_W), .CAP(SCORE_MAX)) u_score (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_clean && w_frame_wrap),
    .i_clear (w_start),
    .o_score (score)
  );

  assign eng.start_erase   = (r_state == ST_ERASE);
  assign eng.move_en       = (r_state == ST_MOVE);
  assign eng.start_draw    = (r_state == ST_DRAW);
  assign eng.detectCollide = (r_state == ST_DETECT);
  assign playing           = (r_state != ST_IDLE) && (r_state != ST_OVER);
  assign game_over         = (r_state == ST_OVER);
  assign lives             = r_lives;
  assign frame_overrun     = r_overrun;
endmodule
